// File: rtl/knap_search_ctrl.sv
// knap_search_ctrl: exhaustive 0/1 knapsack subset search controller.
//
// Walks every subset index idx = 0 .. 2^N_ITEMS-1, one per clock, and keeps
// the best subset whose total value >= MIN_VALUE and total weight <= MAX_WEIGHT.
// "Best" means the highest value; a tie on value goes to the lower weight, and
// a full tie keeps the earlier index.
//
// Optional feature (compile-time macro KNAP_EARLY_EXIT_EN): stop at the first
// valid subset in index order instead of scanning all of them.
//
// Ports:
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   start        request a search (sampled only in IDLE)
//   abort        terminate an active scan (no done pulse)
//   busy         high while scanning
//   done         one-cycle pulse when a search completes
//   found        at least one subset satisfied both constraints
//   best_subset  bit i set = item i included
//   best_value   total value of best_subset
//   best_weight  total weight of best_subset
//   valid_count  number of valid subsets scanned
module knap_search_ctrl #(
    parameter int unsigned N_ITEMS = 7,
    parameter int unsigned VW      = 8,
    parameter logic [N_ITEMS*VW-1:0] ITEM_VALUES =
        {8'd10, 8'd12, 8'd10, 8'd1, 8'd2, 8'd2, 8'd4},
    parameter logic [N_ITEMS*VW-1:0] ITEM_WEIGHTS =
        {8'd2, 8'd2, 8'd4, 8'd1, 8'd2, 8'd1, 8'd12},
    parameter int unsigned MIN_VALUE  = 15,
    parameter int unsigned MAX_WEIGHT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic [N_ITEMS-1:0] best_subset,
    output logic [31:0]        best_value,
    output logic [31:0]        best_weight,
    output logic [N_ITEMS:0]   valid_count
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_t;

    localparam logic [N_ITEMS-1:0] IdxOne = 1;
    localparam logic [N_ITEMS:0]   VcOne  = 1;

    state_t             state_q;
    logic [N_ITEMS-1:0] idx_q;
    logic               busy_q, done_q, found_q;
    logic [N_ITEMS-1:0] best_subset_q;
    logic [31:0]        best_value_q, best_weight_q;
    logic [N_ITEMS:0]   valid_count_q;

    logic [31:0] sum_value, sum_weight;
    logic        is_valid, is_better, is_last;

    // Totals of the subset currently addressed by idx.
    always_comb begin
        sum_value  = '0;
        sum_weight = '0;
        for (int i = 0; i < int'(N_ITEMS); i++) begin
            if (idx_q[i]) begin
                sum_value  = sum_value + 32'(ITEM_VALUES[i*VW +: VW]);
                sum_weight = sum_weight + 32'(ITEM_WEIGHTS[i*VW +: VW]);
            end
        end
        is_valid  = (sum_value >= MIN_VALUE) && (sum_weight <= MAX_WEIGHT);
        // Strict comparisons so that a full tie keeps the earlier index.
        is_better = !found_q || (sum_value > best_value_q) ||
                    ((sum_value == best_value_q) && (sum_weight < best_weight_q));
        is_last   = &idx_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            best_subset_q <= '0;
            best_value_q  <= '0;
            best_weight_q <= '0;
            valid_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q       <= StScan;
                        busy_q        <= 1'b1;
                        idx_q         <= '0;
                        found_q       <= 1'b0;
                        best_subset_q <= '0;
                        best_value_q  <= '0;
                        best_weight_q <= '0;
                        valid_count_q <= '0;
                    end
                end
                StScan: begin
                    if (abort) begin
                        // The subset at this edge is dropped; results keep partial values.
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        if (is_valid) begin
                            valid_count_q <= valid_count_q + VcOne;
                            if (is_better) begin
                                found_q       <= 1'b1;
                                best_subset_q <= idx_q;
                                best_value_q  <= sum_value;
                                best_weight_q <= sum_weight;
                            end
                        end
`ifdef KNAP_EARLY_EXIT_EN
                        if (is_valid || is_last) begin
`else
                        if (is_last) begin
`endif
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                        end else begin
                            idx_q <= idx_q + IdxOne;
                        end
                    end
                end
                StDone: begin
                    // done is registered here, so it shows in the cycle after DONE.
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign found       = found_q;
    assign best_subset = best_subset_q;
    assign best_value  = best_value_q;
    assign best_weight = best_weight_q;
    assign valid_count = valid_count_q;

endmodule

// File: tb/tb_knap_search_ctrl.sv
// Directed bench for knap_search_ctrl: default parameters (u0), an unreachable
// value bound (u1) and both bounds set exactly at the best subset (u2).
module tb_knap_search_ctrl;

`ifdef KNAP_EARLY_EXIT_EN
    localparam int D0       = 32;
    localparam int SUB0     = 'h1E;
    localparam int VAL0     = 15;
    localparam int WT0      = 8;
    localparam int D2       = 128;
    localparam int ABORT_AT = 20;
`else
    localparam int D0       = 129;
    localparam int SUB0     = 'h7E;
    localparam int VAL0     = 37;
    localparam int WT0      = 12;
    localparam int D2       = 129;
    localparam int ABORT_AT = 50;
`endif
    localparam int D1 = 129;

    logic clk = 1'b0;
    logic rst_n, start, abort;
    always #5 clk = ~clk;

    logic        busy0, done0, found0, busy1, done1, found1, busy2, done2, found2;
    logic [6:0]  sub0, sub1, sub2;
    logic [31:0] val0, val1, val2, wt0, wt1, wt2;
    logic [7:0]  vc0, vc1, vc2;

    int checks = 0;
    int failures = 0;

    knap_search_ctrl u0 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy0), .done(done0), .found(found0), .best_subset(sub0),
        .best_value(val0), .best_weight(wt0), .valid_count(vc0)
    );

    knap_search_ctrl #(.MIN_VALUE(100)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy1), .done(done1), .found(found1), .best_subset(sub1),
        .best_value(val1), .best_weight(wt1), .valid_count(vc1)
    );

    knap_search_ctrl #(.MIN_VALUE(37), .MAX_WEIGHT(12)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .busy(busy2), .done(done2), .found(found2), .best_subset(sub2),
        .best_value(val2), .best_weight(wt2), .valid_count(vc2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_u0_results(input string tag);
        check({tag, "_found"}, 32'(found0), 1);
        check({tag, "_subset"}, 32'(sub0), SUB0);
        check({tag, "_value"}, val0, VAL0);
        check({tag, "_weight"}, wt0, WT0);
`ifdef KNAP_EARLY_EXIT_EN
        check({tag, "_vcount"}, 32'(vc0), 1);
`endif
    endtask

    // Pulse start at edge 0, optionally pulse it again at edge restart_at
    // (while busy), then watch 200 edges for done on each instance.
    task automatic run_scan(input int restart_at, output int e0, output int e1,
                            output int e2, output int n0);
        e0 = -1; e1 = -1; e2 = -1; n0 = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int e = 1; e <= 200; e++) begin
            if (e == restart_at) begin
                @(negedge clk) start = 1'b1;
            end
            @(posedge clk);
            #1 start = 1'b0;
            if (done0) begin
                if (e0 < 0) e0 = e;
                n0++;
            end
            if (done1 && e1 < 0) e1 = e;
            if (done2 && e2 < 0) e2 = e;
        end
    endtask

    initial begin
        int e0, e1, e2, n0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_found", 32'(found0), 0);
        check("rst_subset", 32'(sub0), 0);
        check("rst_value", val0, 0);
        check("rst_weight", wt0, 0);
        check("rst_vcount", 32'(vc0), 0);
        @(negedge clk) rst_n = 1'b1;

        // Abort while idle does nothing.
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("idle_abort_busy", 32'(busy0), 0);
        check("idle_abort_done", 32'(done0), 0);

        // Full scan on all three instances.
        run_scan(0, e0, e1, e2, n0);
        check("scan1_done_edge", e0, D0);
        check("scan1_done_width", n0, 1);
        check_u0_results("scan1");
        check("scan1_busy_after", 32'(busy0), 0);
        check("min100_done_edge", e1, D1);
        check("min100_found", 32'(found1), 0);
        check("min100_subset", 32'(sub1), 0);
        check("min100_vcount", 32'(vc1), 0);
        check("bound_done_edge", e2, D2);
        check("bound_found", 32'(found2), 1);
        check("bound_subset", 32'(sub2), 'h7E);
        check("bound_vcount", 32'(vc2), 1);
        check("bound_value", val2, 37);
        check("bound_weight", wt2, 12);

        // Abort mid-scan: busy drops, no done pulse.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (ABORT_AT - 2) @(posedge clk);
        @(negedge clk) abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort_busy", 32'(busy0), 0);
        n0 = 0;
        for (int e = 0; e < 150; e++) begin
            @(posedge clk);
            #1;
            if (done0) n0++;
        end
        check("abort_no_done", n0, 0);
        check("abort_still_idle", 32'(busy0), 0);

        // Rescan after abort gives the same results.
        run_scan(0, e0, e1, e2, n0);
        check("scan2_done_edge", e0, D0);
        check_u0_results("scan2");

        // Reset at edge 60 of a scan clears everything immediately.
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (60) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(busy0), 0);
        check("mid_rst_done", 32'(done0), 0);
        check("mid_rst_found", 32'(found0), 0);
        check("mid_rst_subset", 32'(sub0), 0);
        check("mid_rst_value", val0, 0);
        check("mid_rst_weight", wt0, 0);
        check("mid_rst_vcount", 32'(vc0), 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_idle", 32'(busy0), 0);

        // Start again, with a redundant start while busy at edge 10.
        run_scan(10, e0, e1, e2, n0);
        check("scan3_done_edge", e0, D0);
        check("scan3_done_width", n0, 1);
        check_u0_results("scan3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
